// File: rtl/sparse_term_scheduler.sv
// sparse_term_scheduler
//
// Purpose:
//   Run-level sequencer for the sparse-polynomial multiply controller. A run
//   optionally zero-fills the accumulator memory, then hands the controller
//   one job per sparse word, starting at a configurable sparse-memory
//   address. The scheduler waits for each job to finish before issuing the
//   next one. A watchdog guards every job. The host can abort a run at any
//   time.
//
// Ports:
//   clk, rst_n            clock; asynchronous active-low reset
//   cfg_start_i           start pulse; only looked at while idle
//   cfg_abort_i           abort level; honoured in any non-idle state
//   cfg_clear_acc_i       zero-fill the accumulator before the first job
//   cfg_num_terms_i       number of sparse words in the run
//   cfg_base_addr_i       sparse-memory address of the first word
//   ctrl_start_o          one-cycle job start to the controller
//   ctrl_sparse_addr_o    sparse word address of the current job
//   ctrl_busy_i           controller busy; a job start waits for it to drop
//   ctrl_done_i           controller job complete
//   clr_we_o, clr_addr_o  accumulator clear write enable and address
//   clr_data_o            accumulator clear data; always zero
//   acc_sel_o             1 while the scheduler owns the accumulator write port
//   busy_o                run in progress
//   done_o                one-cycle run-complete pulse
//   err_o, err_code_o     sticky error flag and cause
//                         (1 timeout, 2 bad count, 3 aborted)
//   terms_done_o          jobs completed in the current or last run

`timescale 1ns/1ps

module sparse_term_scheduler #(
    parameter int WORD_WIDTH      = 32,
    parameter int ACC_WORDS       = 553,
    parameter int MEM_SPARSE_SIZE = 50,
    parameter int TIMEOUT_CYCLES  = 65535
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  cfg_start_i,
    input  logic                  cfg_abort_i,
    input  logic                  cfg_clear_acc_i,
    input  logic [5:0]            cfg_num_terms_i,
    input  logic [9:0]            cfg_base_addr_i,
    output logic                  ctrl_start_o,
    output logic [9:0]            ctrl_sparse_addr_o,
    input  logic                  ctrl_busy_i,
    input  logic                  ctrl_done_i,
    output logic                  clr_we_o,
    output logic [9:0]            clr_addr_o,
    output logic [WORD_WIDTH-1:0] clr_data_o,
    output logic                  acc_sel_o,
    output logic                  busy_o,
    output logic                  done_o,
    output logic                  err_o,
    output logic [1:0]            err_code_o,
    output logic [5:0]            terms_done_o
);

    typedef enum logic [2:0] {
        IDLE,
        CLEAR,
        ISSUE,
        WAIT,
        FINISH,
        ERROR
    } state_t;

    localparam logic [9:0]  LAST_CLR_ADDR = 10'(ACC_WORDS - 1);
    localparam logic [15:0] WDOG_LAST     = 16'(TIMEOUT_CYCLES - 1);
    localparam logic [6:0]  MAX_TERMS     = 7'(MEM_SPARSE_SIZE);

    localparam logic [1:0] CODE_NONE    = 2'd0;
    localparam logic [1:0] CODE_TIMEOUT = 2'd1;
    localparam logic [1:0] CODE_BADNUM  = 2'd2;
    localparam logic [1:0] CODE_ABORT   = 2'd3;

    state_t      state_q;
    logic [5:0]  numTerms_q;
    logic [9:0]  baseAddr_q;
    logic [9:0]  clrAddr_q;
    logic [15:0] wdog_q;
    logic [1:0]  pendCode_q;
    logic        ctrlStart_q;
    logic [9:0]  ctrlAddr_q;
    logic        clrWe_q;
    logic        accSel_q;
    logic        busy_q;
    logic        done_q;
    logic        err_q;
    logic [1:0]  errCode_q;
    logic [5:0]  termsDone_q;

    logic [5:0]  termsNext_d;
    logic [9:0]  issueAddr_d;

    // Next job address and job count. The address wraps at the 10-bit
    // boundary on purpose, so a run may straddle the top of sparse memory.
    always_comb begin
        termsNext_d = termsDone_q + 6'd1;
        issueAddr_d = baseAddr_q + {4'b0000, termsDone_q};
    end

    // Run sequencer. Every output is a register, so a state's visible
    // effect on done/err shows up in the cycle after that state. The error
    // cause is held in pendCode_q until ERROR publishes it together with err.
    // Abort is checked before the state case, so it wins over a ctrl_done
    // or a watchdog expiry in the same cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            numTerms_q  <= '0;
            baseAddr_q  <= '0;
            clrAddr_q   <= '0;
            wdog_q      <= '0;
            pendCode_q  <= CODE_NONE;
            ctrlStart_q <= 1'b0;
            ctrlAddr_q  <= '0;
            clrWe_q     <= 1'b0;
            accSel_q    <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            err_q       <= 1'b0;
            errCode_q   <= CODE_NONE;
            termsDone_q <= '0;
        end else begin
            ctrlStart_q <= 1'b0;
            done_q      <= 1'b0;
            if (cfg_abort_i && (state_q != IDLE)) begin
                state_q   <= IDLE;
                busy_q    <= 1'b0;
                clrWe_q   <= 1'b0;
                accSel_q  <= 1'b0;
                err_q     <= 1'b1;
                errCode_q <= CODE_ABORT;
            end else begin
                case (state_q)
                    IDLE: begin
                        if (cfg_start_i) begin
                            numTerms_q  <= cfg_num_terms_i;
                            baseAddr_q  <= cfg_base_addr_i;
                            err_q       <= 1'b0;
                            errCode_q   <= CODE_NONE;
                            termsDone_q <= '0;
                            busy_q      <= 1'b1;
                            if ({1'b0, cfg_num_terms_i} > MAX_TERMS) begin
                                pendCode_q <= CODE_BADNUM;
                                state_q    <= ERROR;
                            end else if (cfg_clear_acc_i) begin
                                clrAddr_q <= '0;
                                clrWe_q   <= 1'b1;
                                accSel_q  <= 1'b1;
                                state_q   <= CLEAR;
                            end else if (cfg_num_terms_i == 6'd0) begin
                                state_q <= FINISH;
                            end else begin
                                state_q <= ISSUE;
                            end
                        end
                    end
                    CLEAR: begin
                        if (clrAddr_q == LAST_CLR_ADDR) begin
                            clrWe_q  <= 1'b0;
                            accSel_q <= 1'b0;
                            state_q  <= (numTerms_q == 6'd0) ? FINISH : ISSUE;
                        end else begin
                            clrAddr_q <= clrAddr_q + 10'd1;
                        end
                    end
                    ISSUE: begin
                        ctrlAddr_q <= issueAddr_d;
                        if (!ctrl_busy_i) begin
                            ctrlStart_q <= 1'b1;
                            wdog_q      <= '0;
                            state_q     <= WAIT;
                        end
                    end
                    WAIT: begin
                        if (ctrl_done_i) begin
                            termsDone_q <= termsNext_d;
                            state_q     <= (termsNext_d == numTerms_q) ? FINISH : ISSUE;
                        end else if (wdog_q == WDOG_LAST) begin
                            pendCode_q <= CODE_TIMEOUT;
                            state_q    <= ERROR;
                        end else begin
                            wdog_q <= wdog_q + 16'd1;
                        end
                    end
                    FINISH: begin
                        done_q  <= 1'b1;
                        busy_q  <= 1'b0;
                        state_q <= IDLE;
                    end
                    ERROR: begin
                        err_q     <= 1'b1;
                        errCode_q <= pendCode_q;
                        busy_q    <= 1'b0;
                        state_q   <= IDLE;
                    end
                    default: begin
                        state_q <= IDLE;
                    end
                endcase
            end
        end
    end

    assign ctrl_start_o       = ctrlStart_q;
    assign ctrl_sparse_addr_o = ctrlAddr_q;
    assign clr_we_o           = clrWe_q;
    assign clr_addr_o         = clrAddr_q;
    assign clr_data_o         = '0;
    assign acc_sel_o          = accSel_q;
    assign busy_o             = busy_q;
    assign done_o             = done_q;
    assign err_o              = err_q;
    assign err_code_o         = errCode_q;
    assign terms_done_o       = termsDone_q;

endmodule

// File: tb/tb_sparse_term_scheduler.sv
// tb_sparse_term_scheduler
//
// Purpose:
//   Directed bench for sparse_term_scheduler. Each scenario describes a run:
//   its configuration, how the controller answers, and any abort or stray
//   start. From that description a timeline model predicts every output for
//   every cycle of the run. Cycle 0 is the cycle where cfg_start is high.
//   The DUT is built with TIMEOUT_CYCLES = 20 so that watchdog runs stay short.

`timescale 1ns/1ps

module tb_sparse_term_scheduler;

    localparam int ACC  = 553;
    localparam int MAXS = 50;
    localparam int TMO  = 20;
    localparam int MAXC = 1024;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        cfg_start, cfg_abort, cfg_clear_acc;
    logic [5:0]  cfg_num_terms;
    logic [9:0]  cfg_base_addr;
    logic        ctrl_start;
    logic [9:0]  ctrl_sparse_addr;
    logic        ctrl_busy, ctrl_done;
    logic        clr_we;
    logic [9:0]  clr_addr;
    logic [31:0] clr_data;
    logic        acc_sel, busy, done, err;
    logic [1:0]  err_code;
    logic [5:0]  terms_done;

    always #5 clk = ~clk;

    sparse_term_scheduler #(
        .WORD_WIDTH      (32),
        .ACC_WORDS       (ACC),
        .MEM_SPARSE_SIZE (MAXS),
        .TIMEOUT_CYCLES  (TMO)
    ) dut (
        .clk                (clk),
        .rst_n              (rst_n),
        .cfg_start_i        (cfg_start),
        .cfg_abort_i        (cfg_abort),
        .cfg_clear_acc_i    (cfg_clear_acc),
        .cfg_num_terms_i    (cfg_num_terms),
        .cfg_base_addr_i    (cfg_base_addr),
        .ctrl_start_o       (ctrl_start),
        .ctrl_sparse_addr_o (ctrl_sparse_addr),
        .ctrl_busy_i        (ctrl_busy),
        .ctrl_done_i        (ctrl_done),
        .clr_we_o           (clr_we),
        .clr_addr_o         (clr_addr),
        .clr_data_o         (clr_data),
        .acc_sel_o          (acc_sel),
        .busy_o             (busy),
        .done_o             (done),
        .err_o              (err),
        .err_code_o         (err_code),
        .terms_done_o       (terms_done)
    );

    typedef struct {
        bit clr;
        int num;
        int base;
        int delay;
        int busyFrom;
        int busyLen;
        int abortAt;
        int restartAt;
    } scen_t;

    bit eCS[MAXC];
    bit eClrWe[MAXC];
    bit eAcc[MAXC];
    bit eBusy[MAXC];
    bit eDone[MAXC];
    bit eErr[MAXC];
    int eAddr[MAXC];
    int eClrAddr[MAXC];
    int eCode[MAXC];
    int eTerms[MAXC];
    int endCycle;

    int cycle  = 0;
    bit active = 1'b0;
    int total  = 0;
    int bad    = 0;

    // One comparison: count it, and report it if it differs.
    task automatic checkOutput(input string name, input int cyc,
                               input logic [31:0] got, input logic [31:0] want);
        total++;
        if (got !== want) begin
            bad++;
            if (bad <= 40)
                $display("[TB] FAIL %s cycle=%0d got=%0d want=%0d", name, cyc, got, want);
        end
    endtask

    function automatic scen_t mk(input bit clr, input int num, input int base,
                                 input int delay, input int busyFrom, input int busyLen,
                                 input int abortAt, input int restartAt);
        scen_t s;
        s.clr = clr; s.num = num; s.base = base; s.delay = delay;
        s.busyFrom = busyFrom; s.busyLen = busyLen;
        s.abortAt = abortAt; s.restartAt = restartAt;
        return s;
    endfunction

    function automatic bit busyIn(input scen_t s, input int c);
        return (c >= s.busyFrom) && (c < s.busyFrom + s.busyLen);
    endfunction

    // Timeline model. Every run is a chain of phases with known lengths.
    // The phases are: optional clear of ACC cycles, then per job the ISSUE
    // cycles until ctrl_busy is low, a start one cycle later, and a wait until
    // done or watchdog. The chain ends with one wrap-up cycle, after which
    // done or err becomes visible. An abort truncates the chain.
    task automatic buildModel(input scen_t s);
        int  t, code, endC, c, st, d, frozen;
        bit  ok;
        for (int i = 0; i < MAXC; i++) begin
            eCS[i] = 0; eClrWe[i] = 0; eAcc[i] = 0; eBusy[i] = 0; eDone[i] = 0;
            eErr[i] = 0; eAddr[i] = 0; eClrAddr[i] = 0; eCode[i] = 0; eTerms[i] = 0;
        end
        t = 1; code = 0; endC = 2; ok = 1'b1;
        if (s.num > MAXS) begin
            code = 2;
            endC = 2;
        end else begin
            if (s.clr) begin
                for (int i = 0; i < ACC; i++) begin
                    eClrWe[t + i] = 1; eAcc[t + i] = 1; eClrAddr[t + i] = i;
                end
                t += ACC;
            end
            for (int k = 0; k < s.num && ok; k++) begin
                c = t;
                while (busyIn(s, c)) c++;
                st = c + 1;
                eCS[st] = 1;
                eAddr[st] = (s.base + k) % 1024;
                if (s.delay > 0 && s.delay < TMO) begin
                    d = st + s.delay;
                    for (int cc = d + 1; cc < MAXC; cc++) eTerms[cc] = k + 1;
                    t = d + 1;
                end else begin
                    code = 1;
                    endC = st + TMO + 1;
                    ok = 1'b0;
                end
            end
            if (ok) begin
                eDone[t + 1] = 1;
                endC = t + 1;
            end
        end
        for (int i = 1; i < endC; i++) eBusy[i] = 1;
        if (s.abortAt > 0 && s.abortAt < endC) begin
            frozen = eTerms[s.abortAt];
            for (int i = s.abortAt + 1; i < MAXC; i++) begin
                eCS[i] = 0; eDone[i] = 0; eClrWe[i] = 0; eAcc[i] = 0;
                eBusy[i] = 0; eTerms[i] = frozen;
            end
            code = 3;
            endC = s.abortAt + 1;
        end
        for (int i = endC; i < MAXC; i++) begin
            eErr[i] = (code != 0);
            eCode[i] = code;
        end
        endCycle = endC;
    endtask

    // Drives one run. The controller responder pulses ctrl_done a fixed
    // number of cycles after each ctrl_start it sees. A delay of 0 means it
    // never answers.
    task automatic applyStimulus(input scen_t s);
        int pend;
        int runLen;
        pend = -1;
        buildModel(s);
        runLen = endCycle + 4;
        @(posedge clk); #1;
        cycle         = 0;
        active        = 1'b0;
        cfg_clear_acc = s.clr;
        cfg_num_terms = 6'(s.num);
        cfg_base_addr = 10'(s.base);
        cfg_start     = 1'b1;
        cfg_abort     = 1'b0;
        ctrl_busy     = busyIn(s, 0);
        ctrl_done     = 1'b0;
        for (int k = 1; k <= runLen; k++) begin
            @(posedge clk); #1;
            cycle     = k;
            active    = 1'b1;
            cfg_start = (k == s.restartAt);
            cfg_abort = (k == s.abortAt);
            ctrl_busy = busyIn(s, k);
            if (ctrl_start === 1'b1 && s.delay > 0) pend = k + s.delay;
            ctrl_done = (k == pend);
        end
        @(posedge clk); #1;
        active    = 1'b0;
        cfg_start = 1'b0;
        cfg_abort = 1'b0;
        ctrl_busy = 1'b0;
        ctrl_done = 1'b0;
    endtask

    // Per-cycle comparison against the timeline, on the falling edge.
    always @(negedge clk) begin
        if (active) begin
            checkOutput("busy",       cycle, busy,       eBusy[cycle]);
            checkOutput("ctrl_start", cycle, ctrl_start, eCS[cycle]);
            checkOutput("done",       cycle, done,       eDone[cycle]);
            checkOutput("err",        cycle, err,        eErr[cycle]);
            checkOutput("err_code",   cycle, err_code,   eCode[cycle]);
            checkOutput("terms_done", cycle, terms_done, eTerms[cycle]);
            checkOutput("clr_we",     cycle, clr_we,     eClrWe[cycle]);
            checkOutput("acc_sel",    cycle, acc_sel,    eAcc[cycle]);
            checkOutput("clr_data",   cycle, clr_data,   0);
            if (eCS[cycle])
                checkOutput("ctrl_sparse_addr", cycle, ctrl_sparse_addr, eAddr[cycle]);
            if (eClrWe[cycle])
                checkOutput("clr_addr", cycle, clr_addr, eClrAddr[cycle]);
        end
    end

    initial begin
        rst_n         = 1'b0;
        cfg_start     = 1'b0;
        cfg_abort     = 1'b0;
        cfg_clear_acc = 1'b0;
        cfg_num_terms = '0;
        cfg_base_addr = '0;
        ctrl_busy     = 1'b0;
        ctrl_done     = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        checkOutput("rst_busy",       0, busy,       0);
        checkOutput("rst_ctrl_start", 0, ctrl_start, 0);
        checkOutput("rst_clr_we",     0, clr_we,     0);
        checkOutput("rst_acc_sel",    0, acc_sel,    0);
        checkOutput("rst_err",        0, err,        0);
        checkOutput("rst_terms_done", 0, terms_done, 0);
        rst_n = 1'b1;

        // Three jobs, 5-cycle controller, stray cfg_start while busy.
        applyStimulus(mk(1'b0, 3, 10, 5, 0, 0, 0, 4));
        checkOutput("pin_start_a", 0, eCS[2], 1);
        checkOutput("pin_start_b", 0, eCS[9], 1);
        checkOutput("pin_start_c", 0, eCS[16], 1);
        checkOutput("pin_addr_c",  0, eAddr[16], 12);
        checkOutput("pin_done",    0, eDone[23], 1);
        checkOutput("run1_terms",  0, terms_done, 3);
        checkOutput("run1_err",    0, err, 0);

        // Accumulator clear, then a single job.
        applyStimulus(mk(1'b1, 1, 7, 3, 0, 0, 0, 0));
        checkOutput("pin_clr_last", 0, eClrAddr[553], 552);
        checkOutput("pin_clr_off",  0, eClrWe[554], 0);
        checkOutput("pin_clr_job",  0, eCS[555], 1);

        // Controller never answers: watchdog after 20 WAIT cycles.
        applyStimulus(mk(1'b0, 2, 0, 0, 0, 0, 0, 0));
        checkOutput("pin_tmo_busy", 0, eBusy[22], 1);
        checkOutput("pin_tmo_err",  0, eErr[23], 1);
        checkOutput("run3_code",    0, err_code, 1);
        checkOutput("run3_terms",   0, terms_done, 0);

        // Too many terms, then an empty run.
        applyStimulus(mk(1'b0, 51, 5, 3, 0, 0, 0, 0));
        checkOutput("run4_code", 0, err_code, 2);
        applyStimulus(mk(1'b0, 0, 20, 3, 0, 0, 0, 0));
        checkOutput("pin_empty_done", 0, eDone[2], 1);

        // Abort on clear word 100.
        applyStimulus(mk(1'b1, 4, 0, 3, 0, 0, 101, 0));
        checkOutput("run6_code", 0, err_code, 3);

        // ctrl_busy held for 7 cycles on ISSUE entry; address wrap at 1023.
        applyStimulus(mk(1'b0, 2, 1023, 4, 1, 7, 0, 0));
        checkOutput("pin_wrap_a", 0, eAddr[9], 1023);
        checkOutput("pin_wrap_b", 0, eAddr[15], 0);
        checkOutput("pin_wrap_d", 0, eDone[21], 1);

        // Abort in the same cycle as ctrl_done: abort wins, count frozen.
        applyStimulus(mk(1'b0, 2, 100, 3, 0, 0, 5, 0));
        checkOutput("run8_terms", 0, terms_done, 0);

        // Clear with zero terms, and done on the last watchdog cycle.
        applyStimulus(mk(1'b1, 0, 0, 3, 0, 0, 0, 0));
        applyStimulus(mk(1'b0, 1, 33, 19, 0, 0, 0, 0));
        checkOutput("run10_err", 0, err, 0);

        // Reset in the middle of a clear phase.
        @(posedge clk); #1;
        cfg_clear_acc = 1'b1;
        cfg_num_terms = 6'd2;
        cfg_start     = 1'b1;
        @(posedge clk); #1;
        cfg_start = 1'b0;
        repeat (9) @(posedge clk);
        #1;
        checkOutput("mid_clr_active", 0, clr_we, 1);
        rst_n = 1'b0;
        #1;
        checkOutput("mid_rst_clr_we",  0, clr_we, 0);
        checkOutput("mid_rst_acc_sel", 0, acc_sel, 0);
        checkOutput("mid_rst_busy",    0, busy, 0);
        checkOutput("mid_rst_addr",    0, clr_addr, 0);
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(posedge clk); #1;
            checkOutput("post_rst_clr_we", i, clr_we, 0);
            checkOutput("post_rst_start",  i, ctrl_start, 0);
            checkOutput("post_rst_busy",   i, busy, 0);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
